// File: rtl/loopback_checker.sv
// Receive-side checker for the HPIO loopback counter pattern.
// Finds the bit rotation, locks to the incrementing stream and counts word errors.
module loopback_checker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             clr_cnt,
  output logic [7:0]       data_out,
  output logic             data_out_valid,
  output logic             locked,
  output logic [2:0]       rot,
  output logic             err_pulse,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] ERR_C  = 8'(ERR_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       expected_q, expected_d;
  logic [7:0]       good_run_q, good_run_d;
  logic [7:0]       err_run_q, err_run_d;
  logic [2:0]       rot_q, rot_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_out_valid_q, data_out_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [7:0] aw;
  logic       wc_inc;
  logic       ec_inc;

  always_comb begin
    aw = data_in;
    case (rot_q)
      3'd0:    aw = data_in;
      3'd1:    aw = {data_in[0],   data_in[7:1]};
      3'd2:    aw = {data_in[1:0], data_in[7:2]};
      3'd3:    aw = {data_in[2:0], data_in[7:3]};
      3'd4:    aw = {data_in[3:0], data_in[7:4]};
      3'd5:    aw = {data_in[4:0], data_in[7:5]};
      3'd6:    aw = {data_in[5:0], data_in[7:6]};
      default: aw = {data_in[6:0], data_in[7]};
    endcase
  end

  always_comb begin
    state_d          = state_q;
    prev_d           = prev_q;
    expected_d       = expected_q;
    good_run_d       = good_run_q;
    err_run_d        = err_run_q;
    rot_d            = rot_q;
    err_pulse_d      = 1'b0;
    wc_inc           = 1'b0;
    ec_inc           = 1'b0;
    data_out_d       = aw;
    data_out_valid_d = data_valid;

    if (data_valid) begin
      case (state_q)
        ST_SEARCH: begin
          prev_d     = aw;
          good_run_d = 8'd0;
          state_d    = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (aw == prev_q + 8'd1) begin
            prev_d     = aw;
            good_run_d = good_run_q + 8'd1;
            if (good_run_q + 8'd1 == LOCK_C) begin
              state_d    = ST_LOCKED;
              expected_d = aw + 8'd1;
            end
          end else begin
            rot_d   = rot_q + 3'd1;
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          // expected advances on every word so one corrupted word costs one error
          expected_d = expected_q + 8'd1;
          wc_inc     = 1'b1;
          if (aw != expected_q) begin
            err_pulse_d = 1'b1;
            ec_inc      = 1'b1;
            err_run_d   = err_run_q + 8'd1;
            if (err_run_q + 8'd1 == ERR_C) begin
              state_d   = ST_SEARCH;
              err_run_d = 8'd0;
            end
          end else begin
            err_run_d = 8'd0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (clr_cnt) begin
      word_count_d = '0;
      err_count_d  = '0;
    end else begin
      if (wc_inc && !(&word_count_q)) word_count_d = word_count_q + CNT_W'(1);
      if (ec_inc && !(&err_count_q))  err_count_d  = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_SEARCH;
      prev_q           <= 8'd0;
      expected_q       <= 8'd0;
      good_run_q       <= 8'd0;
      err_run_q        <= 8'd0;
      rot_q            <= 3'd0;
      data_out_q       <= 8'd0;
      data_out_valid_q <= 1'b0;
      locked_q         <= 1'b0;
      err_pulse_q      <= 1'b0;
      word_count_q     <= '0;
      err_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      prev_q           <= prev_d;
      expected_q       <= expected_d;
      good_run_q       <= good_run_d;
      err_run_q        <= err_run_d;
      rot_q            <= rot_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      locked_q         <= locked_d;
      err_pulse_q      <= err_pulse_d;
      word_count_q     <= word_count_d;
      err_count_q      <= err_count_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign locked         = locked_q;
  assign rot            = rot_q;
  assign err_pulse      = err_pulse_q;
  assign word_count     = word_count_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_loopback_checker.sv
// Directed bench for loopback_checker: lock, rotation search, error counting,
// valid gaps, async reset and counter clear.
module tb_loopback_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        locked;
  logic [2:0]  rot;
  logic        err_pulse;
  logic [31:0] word_count;
  logic [31:0] err_count;

  int n_cmp = 0;
  int n_mis = 0;

  loopback_checker #(.LOCK_COUNT(16), .ERR_LIMIT(4), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .clr_cnt        (clr_cnt),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .locked         (locked),
    .rot            (rot),
    .err_pulse      (err_pulse),
    .word_count     (word_count),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [15:0] t;
    t = {x, x} << r;
    return t[15:8];
  endfunction

  // drive one word, then sample 1 ns after the edge that consumed it
  task automatic cyc(input logic [7:0] d, input logic v, input logic c);
    data_in    = d;
    data_valid = v;
    clr_cnt    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    clr_cnt    = 1'b0;
    data_in    = 8'd0;
    rst        = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int pulses;

    // reset state and basic lock on an unrotated stream
    do_reset();
    check("rst_outs", {18'd0, data_out, data_out_valid, locked, rot, err_pulse}, 32'd0);
    check("rst_wc", word_count, 32'd0);
    check("rst_ec", err_count, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      cyc(8'(i), 1'b1, 1'b0);
      if (i == 5)  check("t1_dout5", {24'd0, data_out}, 32'd5);
      if (i == 15) check("t1_nolock15", {31'd0, locked}, 32'd0);
      if (i == 16) check("t1_lock16", {31'd0, locked}, 32'd1);
    end
    check("t1_rot", {29'd0, rot}, 32'd0);
    check("t1_ec", err_count, 32'd0);
    check("t1_wc", word_count, 32'd983);

    // every rotation of the stream must be found
    for (int r = 0; r < 8; r++) begin
      do_reset();
      cnt = 0;
      for (int k = 0; k < 400 && !locked; k++) begin
        cyc(rotl(8'(cnt), r), 1'b1, 1'b0);
        cnt++;
      end
      check($sformatf("t2_lock_r%0d", r), {31'd0, locked}, 32'd1);
      check($sformatf("t2_rot_r%0d", r), {29'd0, rot}, r);
      cyc(rotl(8'(cnt), r), 1'b1, 1'b0);
      check($sformatf("t2_dout_r%0d", r), {24'd0, data_out}, cnt & 32'hFF);
      cnt++;
    end

    // single corrupted word
    do_reset();
    for (int i = 0; i < 30; i++) cyc(8'(i), 1'b1, 1'b0);
    cyc(8'hA5, 1'b1, 1'b0);
    check("t3_pulse", {31'd0, err_pulse}, 32'd1);
    check("t3_ec", err_count, 32'd1);
    check("t3_locked", {31'd0, locked}, 32'd1);
    pulses = 0;
    for (int i = 31; i <= 50; i++) begin
      cyc(8'(i), 1'b1, 1'b0);
      pulses += int'(err_pulse);
    end
    check("t3_no_more_pulses", pulses, 32'd0);
    check("t3_ec_after", err_count, 32'd1);
    check("t3_wc", word_count, 32'd34);
    check("t3_locked_after", {31'd0, locked}, 32'd1);

    // stream rotation changes 0 -> 5 while locked
    do_reset();
    for (int i = 0; i < 40; i++) cyc(8'(i), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(rotl(8'(40 + k), 5), 1'b1, 1'b0);
      check($sformatf("t4_pulse%0d", k), {31'd0, err_pulse}, 32'd1);
      check($sformatf("t4_locked%0d", k), {31'd0, locked}, (k < 3) ? 32'd1 : 32'd0);
    end
    check("t4_ec4", err_count, 32'd4);
    cnt = 44;
    for (int k = 0; k < 300 && !locked; k++) begin
      cyc(rotl(8'(cnt), 5), 1'b1, 1'b0);
      cnt++;
    end
    check("t4_relock", {31'd0, locked}, 32'd1);
    check("t4_rot5", {29'd0, rot}, 32'd5);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      cyc(rotl(8'(cnt), 5), 1'b1, 1'b0);
      pulses += int'(err_pulse);
      cnt++;
    end
    check("t4_pulses_after", pulses, 32'd0);
    check("t4_ec_final", err_count, 32'd4);

    // gapped valid with a 0xFF -> 0x00 wrap inside LOCKED
    do_reset();
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(8'(32'hE0 + i), 1'b1, 1'b0);
      pulses += int'(err_pulse);
      if (i == 10) check("t5_dov1", {31'd0, data_out_valid}, 32'd1);
      cyc(8'h5A, 1'b0, 1'b0);
      pulses += int'(err_pulse);
      if (i == 10) check("t5_dov0", {31'd0, data_out_valid}, 32'd0);
    end
    check("t5_locked", {31'd0, locked}, 32'd1);
    check("t5_pulses", pulses, 32'd0);
    check("t5_ec", err_count, 32'd0);
    check("t5_wc", word_count, 32'd43);

    // async reset between edges while locked
    do_reset();
    for (int i = 0; i < 30; i++) cyc(8'(i), 1'b1, 1'b0);
    check("t6_pre_locked", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_outs", {18'd0, data_out, data_out_valid, locked, rot, err_pulse}, 32'd0);
    check("t6_async_wc", word_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clr_cnt coincident with an errored word
    do_reset();
    for (int i = 0; i < 25; i++) cyc(8'(i), 1'b1, 1'b0);
    check("t7_wc_pre", word_count, 32'd8);
    cyc(8'hA5, 1'b1, 1'b1);
    check("t7_pulse", {31'd0, err_pulse}, 32'd1);
    check("t7_ec", err_count, 32'd0);
    check("t7_wc", word_count, 32'd0);
    cyc(8'd26, 1'b1, 1'b0);
    check("t7_wc_next", word_count, 32'd1);
    check("t7_ec_next", err_count, 32'd0);
    check("t7_locked", {31'd0, locked}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/loopback_checker.md
# loopback_checker

Receive-side checker for the HPIO loopback test. It consumes the 8-bit parallel words from the RX deserializer, which carry the transmitter's free-running 8-bit counter pattern with an unknown bit rotation. It searches for the rotation, locks to the incremental pattern and counts word errors. It sits directly downstream of the RX deserializer in the `clk_200m` domain, and its outputs feed the ILA probes.

## Interface
Parameters:
- `LOCK_COUNT`, default 16: consecutive good increments required to declare lock (range 1–255).
- `ERR_LIMIT`, default 4: consecutive word errors in LOCKED that drop lock (range 1–255).
- `CNT_W`, default 32: width of the word and error counters.

Ports:
- `clk` in 1: fabric clock (`clk_200m`); the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 8: raw RX word (`data_out_p` from the deserializer).
- `data_valid` in 1: `data_in` qualifier; words with `data_valid`=0 are ignored entirely.
- `clr_cnt` in 1: synchronous clear of `word_count` and `err_count`.
- `data_out` out 8: `data_in` rotated right by `rot`.
- `data_out_valid` out 1: registered copy of `data_valid`.
- `locked` out 1: high while in LOCKED.
- `rot` out 3: current rotation hypothesis.
- `err_pulse` out 1: one-cycle pulse for each errored word while LOCKED.
- `word_count` out `CNT_W`: valid words checked in LOCKED; saturating.
- `err_count` out `CNT_W`: errored words in LOCKED; saturating.

## Operation
- Aligned word: `aw` = low 8 bits of ({`data_in`,`data_in`} >> `rot`). This is a combinational rotate-right.
- FSM states: SEARCH, VERIFY, LOCKED. Registers are `prev`[7:0], `good_run`[7:0] and `err_run`[7:0]. Only valid words advance the FSM.
- SEARCH:
  - On a valid word: `prev`<=`aw`, `good_run`<=0, go to VERIFY.
- VERIFY:
  - On a valid word with `aw` == `prev`+1 (mod 256): `prev`<=`aw`, `good_run`+1.
  - When `good_run`+1 == `LOCK_COUNT`: go to LOCKED and set `expected`<=`aw`+1.
  - On a mismatch: `rot`<=`rot`+1 (7 wraps to 0) and go to SEARCH.
- LOCKED:
  - On every valid word: `expected`<=`expected`+1, whether or not the word matches. A single corrupted word therefore yields exactly one error.
  - Match: `err_run`<=0 and `word_count`+1.
  - Mismatch: `err_pulse`=1, `err_count`+1, `word_count`+1, `err_run`+1.
  - When `err_run`+1 == `ERR_LIMIT`: go to SEARCH with `rot` unchanged and `err_run`<=0.
- 255→0 is a valid increment in every state.
- Counters saturate at all-ones. They increment only in LOCKED.
- `clr_cnt` takes priority over a coincident increment: both counters become 0 and the coincident event is not counted.
- `rot` changes only on a VERIFY mismatch.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `locked`=0, `rot`=0, `err_pulse`=0, `word_count`=0, `err_count`=0. Internal state: SEARCH, `prev`=`expected`=`good_run`=`err_run`=0.
- All outputs are registered.
- `data_out` and `data_out_valid`: 1-cycle latency from `data_in`/`data_valid`, using the `rot` in effect at sampling.
- `err_pulse`, `word_count` and `err_count` update on the edge that samples the word.
- `locked` rises on the edge that samples word `LOCK_COUNT` (0-based) of a correct run. With `data_valid` held high from cycle 0, `locked` is high in cycle `LOCK_COUNT`+1.
- `locked` falls on the edge that samples the `ERR_LIMIT`-th consecutive error.
- Worst-case lock time from a stream start: 8×(`LOCK_COUNT`+1) valid words plus the false-match runs.
- Assertion of `rst` clears all state immediately, regardless of `clk`. After deassertion, the first `clk` edge begins in SEARCH.

## Test plan
- Reset, then a counter stream 0,1,2,… with `data_valid`=1 every cycle (`LOCK_COUNT`=16) → `locked`=1 in cycle 17, `rot`=0. After 1000 words: `err_count`=0, `word_count`=983.
- Stream rotated left by 3 (`data_in`=rotl(cnt,3)) → `locked` asserts with `rot`=3 and `data_out` equal to the plain counter, 1 cycle late. Repeat for all 8 rotations.
- While LOCKED, replace one word with 0xA5 → exactly one `err_pulse`, `err_count`=1, `locked` stays 1, and subsequent words give no errors.
- While LOCKED, change the stream rotation from 0 to 5 (`ERR_LIMIT`=4) → 4 consecutive errors, `locked` falls on the 4th, then relocks with `rot`=5. `err_count` is 4 plus any errors counted after relock, which must be 0.
- Alternate `data_valid` 1/0 while the counter advances only on valid cycles → lock is achieved, no errors, and `word_count` counts only valid words. Include a 0xFF→0x00 wrap.
- Assert `rst` mid-LOCKED between clock edges → all outputs are 0 immediately. Separately, assert `clr_cnt` on the same cycle as an errored word → `err_count`=0 and `word_count`=0 on the next cycle, and `err_pulse` still fires.
